fp12_accumulator: RTL and testbench

- Downstream stage of the fp12 multiplier. Consumes its stream of 12-bit products (1 sign, 5 exp, 6 frac, bias 15) and sums each frame exactly in a wide signed fixed-point register.
- On the frame's last beat, it normalizes the sum back to fp12 and presents it on a valid/ready output.
- Used as the reduction stage of a dot-product datapath: multiplier result/valid_out feed in_data/in_valid.

---
 rtl/fp12_pkg.sv | 34 +++
 rtl/fp12_normalize.sv | 57 +++++
 rtl/fp12_accumulator.sv | 107 ++++++++++
 tb/tb_fp12_accumulator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp12_pkg.sv
// rtl/fp12_pkg.sv - shared fp12 field layout, constants, state type and fixed-point conversion
package fp12_pkg;

    localparam int SIGN_B   = 11;
    localparam int EXP_MSB  = 10;
    localparam int EXP_LSB  = 6;
    localparam int FRAC_W   = 6;
    localparam int BIAS     = 15;
    localparam int EXP_SAT  = 30;
    localparam int FIX_W    = 36;
    // Fractional bits of the fixed-point format: LSB weight is 2^-20.
    localparam int FIX_FRAC = 20;
    localparam logic [10:0] SAT_CODE = 11'h7B0;

    typedef enum logic [1:0] {ACCUM, NORM, HOLD} state_t;

    // Unsigned fixed-point magnitude of an fp12 value; exp 0 flushes to zero,
    // exp 31 is clamped to the largest finite exponent.
    function automatic logic [FIX_W-1:0] fp12_to_fix(input logic [11:0] v);
        logic [4:0]       e;
        logic [FIX_W-1:0] m;
        e = v[EXP_MSB:EXP_LSB];
        if (e == 5'd31) begin
            e = 5'd30;
        end
        m = {{(FIX_W-FRAC_W-1){1'b0}}, 1'b1, v[FRAC_W-1:0]};
        if (e == 5'd0) begin
            fp12_to_fix = '0;
        end else begin
            fp12_to_fix = m << (e - 5'd1);
        end
    endfunction

endpackage

// File: rtl/fp12_normalize.sv
// rtl/fp12_normalize.sv - signed fixed-point accumulator value to fp12 with sat/underflow flags
module fp12_normalize
    import fp12_pkg::*;
#(
    parameter int ACC_W = 44
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    ovf,
    output logic [11:0]             fp,
    output logic                    sat,
    output logic                    uf
);

    localparam int LEAD_W = $clog2(ACC_W);
    // Leading-one index p maps to biased exponent p - OFFS.
    localparam int OFFS   = FIX_FRAC - BIAS;

    logic [ACC_W-1:0]  mag;
    logic [LEAD_W-1:0] lead;
    logic [4:0]        exp5;
    logic [FRAC_W-1:0] frac;
    logic              min_neg;
    logic              neg;

    // Absolute value, leading-one detect, then classify and pack.
    always_comb begin
        neg     = acc[ACC_W-1];
        min_neg = ($unsigned(acc) == {1'b1, {(ACC_W-1){1'b0}}});
        mag     = neg ? $unsigned(-acc) : $unsigned(acc);
        lead    = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) begin
                lead = LEAD_W'(i);
            end
        end
        exp5 = 5'(lead - LEAD_W'(OFFS));
        frac = FRAC_W'(mag >> (lead - LEAD_W'(FRAC_W)));
        fp   = '0;
        sat  = 1'b0;
        uf   = 1'b0;
        // The most-negative value has no representable magnitude; treat as overflow.
        if (ovf || min_neg) begin
            fp  = {neg, SAT_CODE};
            sat = 1'b1;
        end else if (mag != '0) begin
            if (lead <= LEAD_W'(OFFS)) begin
                uf = 1'b1;
            end else if (lead >= LEAD_W'(EXP_SAT + OFFS)) begin
                fp  = {neg, SAT_CODE};
                sat = 1'b1;
            end else begin
                fp = {neg, exp5, frac};
            end
        end
    end

endmodule

// File: rtl/fp12_accumulator.sv
// rtl/fp12_accumulator.sv - exact per-frame fp12 summation with normalized valid/ready result
module fp12_accumulator
    import fp12_pkg::*;
#(
    parameter int ACC_W = 44
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [11:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sat,
    output logic        out_uf
);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum;
    logic [FIX_W-1:0]        fix;
    logic                    ovf;
    logic                    add_ovf;
    logic                    accept;
    logic [11:0]             norm_fp;
    logic                    norm_sat;
    logic                    norm_uf;

    assign in_ready = (state == ACCUM);
    assign accept   = in_ready && in_valid;

    // Convert the incoming beat to signed fixed point and form the candidate sum.
    always_comb begin
        fix     = fp12_to_fix(in_data);
        addend  = $signed({{(ACC_W-FIX_W){1'b0}}, fix});
        if (in_data[SIGN_B]) begin
            addend = -addend;
        end
        sum     = acc + addend;
        add_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end

    fp12_normalize #(
        .ACC_W (ACC_W)
    ) u_normalize (
        .acc (acc),
        .ovf (ovf),
        .fp  (norm_fp),
        .sat (norm_sat),
        .uf  (norm_uf)
    );

    // Frame FSM: accumulate, normalize for one cycle, hold result until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            ovf       <= 1'b0;
            out_data  <= 12'h000;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_uf    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        // Once overflowed, acc is frozen for the rest of the frame.
                        if (!ovf) begin
                            if (add_ovf) begin
                                ovf <= 1'b1;
                            end else begin
                                acc <= sum;
                            end
                        end
                        if (in_last) begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    out_data  <= norm_fp;
                    out_sat   <= norm_sat;
                    out_uf    <= norm_uf;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        out_sat   <= 1'b0;
                        out_uf    <= 1'b0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp12_accumulator.sv
// tb/tb_fp12_accumulator.sv - self-checking bench for fp12_accumulator
module tb_fp12_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_data = 12'h000;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sat;
    logic        out_uf;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [11:0] data;
        logic        sat;
        logic        uf;
    } res_t;

    res_t exp_q[$];
    res_t last_model;
    real  acc_model = 0.0;

    always #5 clk = ~clk;

    fp12_accumulator #(.ACC_W(44)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .out_uf    (out_uf)
    );

    function automatic real pow2(int e);
        real r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real fp12_value(logic [11:0] v);
        int  e;
        real m;
        e = int'(v[10:6]);
        if (e == 0) return 0.0;
        if (e == 31) e = 30;
        m = 1.0 + real'(int'(v[5:0])) / 64.0;
        return (v[11] ? -m : m) * pow2(e - 15);
    endfunction

    function automatic res_t model_norm(real v);
        res_t r;
        real  a;
        real  m;
        int   e;
        int   f;
        logic s;
        r = '0;
        if (v == 0.0) return r;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a >= pow2(23)) begin
            r.data = {s, 11'h7B0};
            r.sat  = 1'b1;
            return r;
        end
        m = a;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        if (e + 15 <= 0) begin
            r.uf = 1'b1;
        end else if (e + 15 >= 30) begin
            r.data = {s, 11'h7B0};
            r.sat  = 1'b1;
        end else begin
            f = $rtoi((m - 1.0) * 64.0);
            r.data = {s, 5'(e + 15), 6'(f)};
        end
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Present one beat and hold it until accepted; model tracks the frame sum.
    task automatic send(logic [11:0] d, logic last);
        int n = 0;
        bit done = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        acc_model = acc_model + fp12_value(d);
        if (last) begin
            last_model = model_norm(acc_model);
            exp_q.push_back(last_model);
            acc_model = 0.0;
        end
    endtask

    task automatic pin(string name, logic [11:0] d, logic s, logic u);
        check(name, 32'({last_model.data, last_model.sat, last_model.uf}), 32'({d, s, u}));
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("result_drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Compare every presented result against the model queue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0].data));
                check("out_sat", 32'(out_sat), 32'(exp_q[0].sat));
                check("out_uf", 32'(out_uf), 32'(exp_q[0].uf));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h000);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_out_uf", 32'(out_uf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single beat: latency and flags.
        send(12'h3C0, 1'b1);
        pin("model_one", 12'h3C0, 1'b0, 1'b0);
        check("norm_out_valid", 32'(out_valid), 32'd0);
        check("norm_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd1);
        wait_done();

        send(12'h3C0, 1'b0); send(12'h3C0, 1'b1);
        pin("model_two", 12'h400, 1'b0, 1'b0);
        wait_done();
        send(12'h3E0, 1'b0); send(12'hBE0, 1'b1);
        pin("model_cancel", 12'h000, 1'b0, 1'b0);
        wait_done();
        send(12'h020, 1'b0); send(12'h3C0, 1'b1);
        pin("model_flush", 12'h3C0, 1'b0, 1'b0);
        wait_done();
        send(12'h041, 1'b0); send(12'h840, 1'b1);
        pin("model_uf", 12'h000, 1'b0, 1'b1);
        wait_done();
        send(12'h7B0, 1'b0); send(12'h7B0, 1'b1);
        pin("model_sat_pos", 12'h7B0, 1'b1, 1'b0);
        wait_done();
        send(12'hFB0, 1'b0); send(12'hFB0, 1'b1);
        pin("model_sat_neg", 12'hFB0, 1'b1, 1'b0);
        wait_done();
        send(12'h3C0, 1'b1);
        pin("model_after_sat", 12'h3C0, 1'b0, 1'b0);
        wait_done();
        send(12'h3C0, 1'b0); send(12'h3E0, 1'b0); send(12'hBC0, 1'b1);
        pin("model_mixed", 12'h3E0, 1'b0, 1'b0);
        wait_done();

        // Backpressure: result held, beats refused.
        out_ready = 1'b0;
        send(12'h3E0, 1'b0); send(12'h3C0, 1'b1);
        pin("model_bp", 12'h410, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_data  = 12'h7B0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_data", 32'(out_data), 32'h410);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        send(12'h3C0, 1'b1);
        pin("model_after_bp", 12'h3C0, 1'b0, 1'b0);
        wait_done();

        // Reset while holding a result.
        out_ready = 1'b0;
        send(12'h3C0, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        check("rst_hold_data", 32'(out_data), 32'h000);
        exp_q.delete();
        acc_model = 0.0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-frame.
        send(12'h7B0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'h000);
        acc_model = 0.0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(12'h3C0, 1'b1);
        pin("model_after_rst", 12'h3C0, 1'b0, 1'b0);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
